// File: rtl/operand_sel_pipe.sv
// operand_sel_pipe: N-channel registered operand selector with valid/ready
// handshaking, direct or round-robin channel choice, and out-of-range select
// detection.
//
// Handshake: an item moves on a port in every cycle where both valid and
// ready are high. Valid never waits on ready. Ready may depend combinationally
// on valid, so in_ready follows in_valid and out_ready within the cycle.
module operand_sel_pipe #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    sel_err
);

  // Round-robin start pointer; always holds a channel index below NUM_IN.
  logic [SEL_W-1:0] ptr;

  logic             load_en;
  logic             found;
  logic             xfer;
  logic [SEL_W-1:0] gnt_chan;
  logic [WIDTH-1:0] gnt_data;
  int               rr_idx;

  // The output register can take an item when empty or draining this cycle.
  assign load_en = !out_valid || out_ready;

  // Choose the candidate channel: sel in direct mode, first valid from ptr
  // in round-robin mode. An out-of-range sel matches no channel.
  always_comb begin
    found    = 1'b0;
    gnt_chan = '0;
    gnt_data = '0;
    rr_idx   = 0;
    if (!mode) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          found    = 1'b1;
          gnt_chan = SEL_W'(i);
          gnt_data = in_data[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        rr_idx = int'(ptr) + k;
        if (rr_idx >= NUM_IN) rr_idx = rr_idx - NUM_IN;
        for (int i = 0; i < NUM_IN; i++) begin
          if (!found && i == rr_idx && in_valid[i]) begin
            found    = 1'b1;
            gnt_chan = SEL_W'(i);
            gnt_data = in_data[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // Grant is one-hot (or zero) and gated by output register availability.
  assign xfer = found && load_en;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = xfer && (gnt_chan == SEL_W'(i));
    end
  end

  // Output register: load on transfer, empty on drain, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_data  <= gnt_data;
      out_chan  <= gnt_chan;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves past the granted channel, only in mode 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer && mode) begin
      ptr <= (int'(gnt_chan) == NUM_IN - 1) ? '0 : gnt_chan + SEL_W'(1);
    end
  end

  // Flag a direct-mode select that names no channel, every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= !mode && (int'(sel) >= NUM_IN);
    end
  end

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Bench for operand_sel_pipe: a default 2-channel instance and a 3-channel
// instance driven with directed vectors and hand-computed expectations.
module tb_operand_sel_pipe;

  logic clk;
  logic rst_n;

  // 2-channel instance (defaults)
  logic [9:0]  a_in_data;
  logic [1:0]  a_in_valid;
  logic [1:0]  a_in_ready;
  logic        a_mode;
  logic [0:0]  a_sel;
  logic [4:0]  a_out_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [0:0]  a_out_chan;
  logic        a_sel_err;

  // 3-channel instance
  logic [14:0] b_in_data;
  logic [2:0]  b_in_valid;
  logic [2:0]  b_in_ready;
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [4:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [1:0]  b_out_chan;
  logic        b_sel_err;

  int n_checks;
  int n_errors;

  operand_sel_pipe dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .mode      (a_mode),
    .sel       (a_sel),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_chan  (a_out_chan),
    .sel_err   (a_sel_err)
  );

  operand_sel_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .mode      (b_mode),
    .sel       (b_sel),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_chan  (b_out_chan),
    .sel_err   (b_sel_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_exp[6];
    int rr2_exp[4];
    n_checks = 0;
    n_errors = 0;

    rst_n       = 1'b0;
    a_in_data   = '0; a_in_valid = '0; a_mode = 1'b0; a_sel = '0; a_out_ready = 1'b1;
    b_in_data   = '0; b_in_valid = '0; b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b1;
    #12;
    rst_n = 1'b1;
    #1;
    check("a_rst_valid", 32'(a_out_valid), 0);
    check("b_rst_ptr", 32'(dut3.ptr), 0);

    // ---- direct mode, 2 channels ----
    a_in_data  = {5'd3, 5'd2};
    a_in_valid = 2'b11;
    a_sel      = 1'b0;
    #1;
    check("dir_ready_sel0", 32'(a_in_ready), 32'b01);
    tick();
    check("dir_data0", 32'(a_out_data), 2);
    check("dir_chan0", 32'(a_out_chan), 0);
    check("dir_valid0", 32'(a_out_valid), 1);
    a_sel = 1'b1;
    #1;
    check("dir_ready_sel1", 32'(a_in_ready), 32'b10);
    tick();
    check("dir_data1", 32'(a_out_data), 3);
    check("dir_chan1", 32'(a_out_chan), 1);
    a_in_valid = 2'b01;
    #1;
    check("dir_ready_novalid", 32'(a_in_ready), 0);
    tick();
    check("dir_valid_drop", 32'(a_out_valid), 0);
    check("dir_data_hold", 32'(a_out_data), 3);

    // ---- back-pressure ----
    a_sel      = 1'b0;
    a_in_data  = {5'd0, 5'd6};
    a_in_valid = 2'b01;
    tick();
    check("bp_load6", 32'(a_out_data), 6);
    a_out_ready = 1'b0;
    a_in_data   = {5'd0, 5'd7};
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready_stall", 32'(a_in_ready), 0);
      tick();
      check("bp_data_hold", 32'(a_out_data), 6);
      check("bp_valid_hold", 32'(a_out_valid), 1);
    end
    a_out_ready = 1'b1;
    #1;
    check("bp_ready_release", 32'(a_in_ready), 32'b01);
    tick();
    check("bp_data7", 32'(a_out_data), 7);
    check("bp_valid7", 32'(a_out_valid), 1);

    // ---- round-robin fairness, 3 channels ----
    b_in_data  = {5'd12, 5'd11, 5'd10};
    b_in_valid = 3'b111;
    b_mode     = 1'b1;
    rr_exp = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_all_chan", 32'(b_out_chan), 32'(rr_exp[i]));
      check("rr_all_data", 32'(b_out_data), 32'(10 + rr_exp[i]));
    end
    b_in_valid = 3'b101;
    rr2_exp = '{0, 2, 0, 2};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_skip1_chan", 32'(b_out_chan), 32'(rr2_exp[i]));
    end
    b_in_valid = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_only2_chan", 32'(b_out_chan), 2);
      check("rr_only2_ptr", 32'(dut3.ptr), 0);
    end

    // ---- out-of-range select ----
    b_in_valid = 3'b111;
    b_mode     = 1'b0;
    b_sel      = 2'd3;
    #1;
    check("oor_ready", 32'(b_in_ready), 0);
    tick();
    check("oor_sel_err", 32'(b_sel_err), 1);
    check("oor_no_xfer", 32'(b_out_valid), 0);
    b_sel = 2'd1;
    #1;
    check("oor_ready_sel1", 32'(b_in_ready), 32'b010);
    tick();
    check("oor_sel_err_clr", 32'(b_sel_err), 0);
    check("oor_chan1", 32'(b_out_chan), 1);
    check("oor_data1", 32'(b_out_data), 11);

    // ---- mode switch preserves ptr ----
    b_mode = 1'b1;
    tick();
    check("ms_rr_chan0", 32'(b_out_chan), 0);
    tick();
    check("ms_rr_chan1", 32'(b_out_chan), 1);
    check("ms_ptr2", 32'(dut3.ptr), 2);
    b_mode = 1'b0;
    b_sel  = 2'd0;
    tick();
    check("ms_dir_chan_a", 32'(b_out_chan), 0);
    tick();
    check("ms_dir_chan_b", 32'(b_out_chan), 0);
    check("ms_ptr_kept", 32'(dut3.ptr), 2);
    b_mode = 1'b1;
    #1;
    check("ms_ready_ch2", 32'(b_in_ready), 32'b100);
    tick();
    check("ms_rr_chan2", 32'(b_out_chan), 2);
    check("ms_ptr_wrap", 32'(dut3.ptr), 0);
    tick();
    check("ms_ptr1", 32'(dut3.ptr), 1);

    // ---- asynchronous reset while items are held ----
    b_out_ready = 1'b0;
    b_mode      = 1'b0;
    b_sel       = 2'd3;
    a_out_ready = 1'b0;
    a_in_valid  = 2'b00;
    tick();
    check("pre_rst_b_valid", 32'(b_out_valid), 1);
    check("pre_rst_b_err", 32'(b_sel_err), 1);
    check("pre_rst_a_valid", 32'(a_out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_a_valid", 32'(a_out_valid), 0);
    check("rst_a_data", 32'(a_out_data), 0);
    check("rst_a_chan", 32'(a_out_chan), 0);
    check("rst_b_valid", 32'(b_out_valid), 0);
    check("rst_b_data", 32'(b_out_data), 0);
    check("rst_b_chan", 32'(b_out_chan), 0);
    check("rst_b_err", 32'(b_sel_err), 0);
    check("rst_b_ptr", 32'(dut3.ptr), 0);
    b_in_valid = 3'b000;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_a_valid", 32'(a_out_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_sel_pipe.md
# operand_sel_pipe

Parametrised N-channel, WIDTH-bit registered operand selector with valid/ready handshaking. It replaces the combinational 2:1 5-bit register-address mux (Reg2loc select) between instruction decode and the register file read ports. It adds:
- a one-entry output register with back-pressure;
- a round-robin mode for sharing one read port among several requesters;
- detection of out-of-range selects.

## Interface
- WIDTH, 5: data width per channel.
- NUM_IN, 2: number of input channels, ≥2.
- SEL_W, 1: select/channel-index width; must equal ceil(log2(NUM_IN)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_data  in  NUM_IN*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready; at most one bit high per cycle.
- mode  in  1  0 = direct select by sel, 1 = round-robin.
- sel  in  SEL_W  channel index used in direct mode.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  out_data holds an untaken item.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_chan  out  SEL_W  source channel index of out_data.
- sel_err  out  1  registered flag: previous cycle had mode=0 with sel ≥ NUM_IN.

## Operation
- **load_en** = !out_valid || out_ready. The output register can take a new item when empty or when draining this cycle.
- **Grant, direct mode (mode=0):**
  - Candidate is channel sel.
  - grant[sel] = load_en && in_valid[sel] && (sel < NUM_IN).
  - All other grants are 0.
- **Grant, round-robin mode (mode=1):**
  - Scan channels ptr, ptr+1, …, wrapping at NUM_IN-1 → 0.
  - The first channel with in_valid high is granted if load_en.
- **Ready and transfer:**
  - in_ready = grant; the grant is combinational from in_valid, out_ready, mode, sel and ptr.
  - A transfer on channel g occurs when in_valid[g] && in_ready[g].
- **On a transfer:** out_data ← channel g data; out_chan ← g; out_valid ← 1.
- **Load_en high with no transfer:**
  - If out_ready=1, out_valid ← 0.
  - out_data and out_chan hold their last values.
- **Load_en low:** out_data, out_chan and out_valid hold (stall).
- **Round-robin pointer ptr (SEL_W bits):**
  - Updates only on a transfer while mode=1: ptr ← (g == NUM_IN-1) ? 0 : g+1.
  - Unchanged in direct mode and on mode switches.
- **sel_err:** sel_err ← (mode==0 && sel ≥ NUM_IN) every cycle, regardless of valid. It can only assert when NUM_IN is not a power of two.
- **Out-of-range select:** a direct-mode sel ≥ NUM_IN never grants. in_ready stays all-zero.

## Timing
- Reset values (asynchronous, while rst_n=0): out_data=0, out_valid=0, out_chan=0, ptr=0, sel_err=0.
- Reset mid-operation discards any held item. in_ready goes all-zero combinationally when out_valid=0 only if no in_valid is high. Note that in_ready still reflects the grant logic while in reset, so benches must not count transfers during reset.
- Latency: a transfer at edge N gives out_valid=1 and new out_data after edge N.
- Throughput: one item per cycle while out_ready stays high.
- Combinational path out_ready → in_ready is intentional. There is no skid buffer.
- **Simultaneous drain and load:** out_valid=1, out_ready=1 and a transfer in the same cycle replace the item with no bubble.
- **Mode or sel change:** takes effect in the same cycle's grant computation. It never corrupts the held item.
- **Stall:** all in_ready are 0 while out_valid=1 && out_ready=0.
- **ptr wrap:** a grant of channel NUM_IN-1 sets ptr to 0.

## Test plan
1. **Reset values.** Drive rst_n=0 asynchronously mid-cycle while out_valid=1 → out_valid, out_data, out_chan, sel_err and ptr all read 0 immediately. Defaults are WIDTH=5, NUM_IN=2.
2. **Direct mode.**
   - Stimulus: in_data={5'd3,5'd2}, both valid, mode=0, out_ready=1; sel=0 then sel=1.
   - Response: out_data=2 with out_chan=0, then out_data=3 with out_chan=1, each one cycle after the transfer.
   - Then in_valid[1]=0 with sel=1 → in_ready=0 and out_valid drops.
3. **Back-pressure.**
   - Load 5'd6, then hold out_ready=0 for 3 cycles.
   - out_data stays 6 and in_ready stays 0 throughout.
   - Raise out_ready with 5'd7 valid → 7 appears the next cycle with no bubble.
4. **Round-robin fairness.**
   - NUM_IN=3, SEL_W=2, all channels valid, mode=1, out_ready=1.
   - out_chan sequence is 0,1,2,0,1,2.
   - Drop channel 1 → sequence is 0,2,0,2.
   - Only channel 2 valid → every grant is 2 and ptr wraps to 0 after each grant.
5. **Out-of-range select.** NUM_IN=3, mode=0, sel=3, all valid → in_ready=000, no transfer, and sel_err=1 one cycle later. With sel=1, sel_err clears the next cycle.
6. **Mode switch.**
   - Run round-robin until ptr=2, then switch to mode=0 with sel=0 for 2 transfers → out_chan=0 both times.
   - Switch back to mode=1 → the first grant is channel 2, since ptr was preserved.
